// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared definitions for the RTC bus sequencer and the DIR_DATO mux/demux stage:
// state encodings, phase codes, default timing and the state-to-strobe decode.
package rtc_bus_pkg;

  localparam int DIV_DEF      = 32;
  localparam int T_SETUP_DEF  = 1;
  localparam int T_STROBE_DEF = 2;
  localparam int T_HOLD_DEF   = 1;
  localparam int T_GAP_DEF    = 1;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_ADDR  = 3'b001;
  localparam logic [2:0] ST_GAP   = 3'b010;
  localparam logic [2:0] ST_WDATA = 3'b011;
  localparam logic [2:0] ST_RDATA = 3'b101;
  localparam logic [2:0] ST_FIN   = 3'b110;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_A_SET = 4'd1,
    S_A_STB = 4'd2,
    S_A_HLD = 4'd3,
    S_GAP   = 4'd4,
    S_D_SET = 4'd5,
    S_D_STB = 4'd6,
    S_D_HLD = 4'd7,
    S_FIN   = 4'd8
  } state_e;

  typedef struct packed {
    logic [2:0] status;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_n;
  } bus_out_t;

  localparam bus_out_t OUT_IDLE = '{status: ST_IDLE, cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, ad_n: 1'b1};

  // The address phase is always a write; only the data phase honours rd.
  function automatic bus_out_t decode_outputs(input state_e s, input logic rd);
    bus_out_t o;
    o = OUT_IDLE;
    case (s)
      S_A_SET, S_A_HLD: begin o.status = ST_ADDR; o.cs_n = 1'b0; o.ad_n = 1'b0; end
      S_A_STB:          begin o.status = ST_ADDR; o.cs_n = 1'b0; o.ad_n = 1'b0; o.wr_n = 1'b0; end
      S_GAP:            begin o.status = ST_GAP; end
      S_D_SET, S_D_HLD: begin o.status = rd ? ST_RDATA : ST_WDATA; o.cs_n = 1'b0; end
      S_D_STB: begin
        o.status = rd ? ST_RDATA : ST_WDATA;
        o.cs_n   = 1'b0;
        o.rd_n   = ~rd;
        o.wr_n   = rd;
      end
      S_FIN:   begin o.status = ST_FIN; end
      default: begin o = OUT_IDLE; end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Request/strobe bundle between the transaction requester and the RTC bus sequencer.
interface rtc_bus_sequencer_if;
  logic       start;
  logic       rw;
  logic       enable_cont_32;
  logic [2:0] Status3bit;
  logic       LE;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       ad_n;
  logic       busy;
  logic       done;

  modport master (
    output start, rw,
    input  enable_cont_32, Status3bit, LE, cs_n, rd_n, wr_n, ad_n, busy, done
  );

  modport slave (
    input  start, rw,
    output enable_cont_32, Status3bit, LE, cs_n, rd_n, wr_n, ad_n, busy, done
  );
endinterface

// File: rtl/rtc_bus_sequencer_tick_divider.sv
// Free-running divide-by-DIV counter producing a registered 1-clock tick, plus the
// combinational look-ahead that is high in the clock just before the tick.
module tick_divider #(
  parameter int DIV = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick,
  output logic o_pre_tick
);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          w_pre_tick;

  assign w_pre_tick = (r_cnt == CW'(DIV - 1));
  assign o_pre_tick = w_pre_tick;
  assign o_tick     = r_tick;

  // Counter wraps naturally; tick is the registered terminal count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= w_pre_tick;
    end
  end
endmodule

// File: rtl/rtc_bus_sequencer.sv
// Tick-paced sequencer issuing one address+data transaction on the multiplexed RTC
// bus per accepted start request.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int DIV      = DIV_DEF,
  parameter int T_SETUP  = T_SETUP_DEF,
  parameter int T_STROBE = T_STROBE_DEF,
  parameter int T_HOLD   = T_HOLD_DEF,
  parameter int T_GAP    = T_GAP_DEF
) (
  input logic               reloj,
  input logic               resetM,
  rtc_bus_sequencer_if.slave bus
);
  localparam int T_MAX_A = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
  localparam int T_MAX_B = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int SEG_W   = $clog2(T_MAX + 1);

  if (T_SETUP < 1 || T_STROBE < 1 || T_HOLD < 1 || T_GAP < 1) begin : g_bad_timing
    $error("rtc_bus_sequencer: every T_* parameter must be at least 1");
  end
  if (DIV < 4 || (DIV & (DIV - 1)) != 0) begin : g_bad_div
    $error("rtc_bus_sequencer: DIV must be a power of two and at least 4");
  end

  state_e           r_state;
  state_e           w_nxt_state;
  logic [SEG_W-1:0] r_seg;
  logic [SEG_W-1:0] w_nxt_seg;
  logic             w_seg_last;
  logic             w_tick;
  logic             w_pre_tick;
  logic             w_accept;
  logic             r_rw;
  logic             r_pending;
  logic             r_busy;
  logic             r_done;
  logic             r_le;
  bus_out_t         r_out;

  tick_divider #(.DIV(DIV)) u_tick (
    .i_clk      (reloj),
    .i_rst      (resetM),
    .o_tick     (w_tick),
    .o_pre_tick (w_pre_tick)
  );

  assign w_accept = bus.start && (r_state == S_IDLE) && !r_pending && !r_busy;

  // Last tick of the current segment, per state duration.
  always_comb begin
    w_seg_last = 1'b1;
    case (r_state)
      S_A_SET, S_D_SET: w_seg_last = (r_seg == SEG_W'(T_SETUP - 1));
      S_A_STB, S_D_STB: w_seg_last = (r_seg == SEG_W'(T_STROBE - 1));
      S_A_HLD, S_D_HLD: w_seg_last = (r_seg == SEG_W'(T_HOLD - 1));
      S_GAP:            w_seg_last = (r_seg == SEG_W'(T_GAP - 1));
      default:          w_seg_last = 1'b1;
    endcase
  end

  // Next state and segment count; nothing moves except on tick clocks.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_seg   = r_seg;
    if (!w_tick) begin
      w_nxt_state = r_state;
    end else if (r_state == S_IDLE) begin
      w_nxt_state = r_pending ? S_A_SET : S_IDLE;
      w_nxt_seg   = '0;
    end else if (!w_seg_last) begin
      w_nxt_seg = r_seg + SEG_W'(1);
    end else begin
      w_nxt_seg = '0;
      case (r_state)
        S_A_SET: w_nxt_state = S_A_STB;
        S_A_STB: w_nxt_state = S_A_HLD;
        S_A_HLD: w_nxt_state = S_GAP;
        S_GAP:   w_nxt_state = S_D_SET;
        S_D_SET: w_nxt_state = S_D_STB;
        S_D_STB: w_nxt_state = S_D_HLD;
        S_D_HLD: w_nxt_state = S_FIN;
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  // State, request bookkeeping and registered bus outputs.
  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      r_state   <= S_IDLE;
      r_seg     <= '0;
      r_rw      <= 1'b0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_le      <= 1'b0;
      r_out     <= OUT_IDLE;
    end else begin
      r_state <= w_nxt_state;
      r_seg   <= w_nxt_seg;
      r_out   <= decode_outputs(w_nxt_state, r_rw);
      r_done  <= (w_nxt_state == S_FIN) && (r_state != S_FIN);
      // LE lands on the tick clock that closes D_STB, while rd_n is still low.
      r_le    <= w_pre_tick && (r_state == S_D_STB) && w_seg_last && r_rw;
      if (w_accept) begin
        r_pending <= 1'b1;
        r_busy    <= 1'b1;
        r_rw      <= bus.rw;
      end else begin
        if (w_tick && (r_state == S_IDLE)) r_pending <= 1'b0;
        if (w_tick && (r_state == S_FIN)) r_busy <= 1'b0;
      end
    end
  end

  assign bus.enable_cont_32 = w_tick;
  assign bus.Status3bit     = r_out.status;
  assign bus.cs_n           = r_out.cs_n;
  assign bus.rd_n           = r_out.rd_n;
  assign bus.wr_n           = r_out.wr_n;
  assign bus.ad_n           = r_out.ad_n;
  assign bus.LE             = r_le;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
endmodule
